// File: rtl/ysyx_25040101_mem_arbiter.sv
// ysyx_25040101_mem_arbiter
//   Two-requester arbiter/sequencer in front of the single data-memory port.
//   IFU (read-only word fetch) and LSU (load/store, 1/2/4 byte, optional
//   sign extension) share the port with round-robin arbitration and one
//   outstanding transaction at a time.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   ifu_req_* / ifu_resp_*   IFU request handshake and response pulse
//   lsu_req_* / lsu_resp_*   LSU request handshake and response pulse
//   mem_req_valid/ready      downstream request handshake
//   mem_addr..mem_sext       registered request fields, stable while in REQ
//   mem_rvalid, mem_rdata    downstream completion and read data
module ysyx_25040101_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_resp_valid,
    output logic [DATA_W-1:0] ifu_resp_data,
    output logic              ifu_resp_err,

    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic              lsu_wen,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [1:0]        lsu_size,
    input  logic              lsu_sext,
    output logic              lsu_resp_valid,
    output logic [DATA_W-1:0] lsu_resp_data,
    output logic              lsu_resp_err,

    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_size,
    output logic              mem_sext,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              wen;
        logic [DATA_W-1:0] wdata;
        logic [1:0]        size;
        logic              sext;
    } req_t;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    state_t             state;
    req_t               req_q;
    req_t               win_req;
    logic               owner;
    logic               last_grant;
    logic [CNT_W-1:0]   cnt;

    logic               grant_ifu;
    logic               grant_lsu;
    logic               accept;
    logic               timeout_hit;
    logic               resp_fire;
    logic [DATA_W-1:0]  resp_data_n;
    logic               resp_err_n;

    // Contention goes to whoever was not served last.
    assign grant_ifu = ifu_req_valid && (!lsu_req_valid || last_grant == OWN_LSU);
    assign grant_lsu = lsu_req_valid && !grant_ifu;

    // Readies are gated by rst so nothing handshakes while reset is held.
    assign ifu_req_ready = (state == IDLE) && !rst && grant_ifu;
    assign lsu_req_ready = (state == IDLE) && !rst && grant_lsu;
    assign accept        = ifu_req_ready || lsu_req_ready;

    always_comb begin
        win_req = '0;
        if (grant_ifu) begin
            win_req.addr = ifu_addr;
            win_req.size = 2'b10;
        end else begin
            win_req.addr  = lsu_addr;
            win_req.wen   = lsu_wen;
            win_req.wdata = lsu_wdata;
            win_req.size  = lsu_size;
            win_req.sext  = lsu_sext;
        end
    end

    // A completion on the final WAIT cycle beats the timeout.
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
    assign resp_fire   = (state == WAIT) && (mem_rvalid || timeout_hit);
    assign resp_err_n  = !mem_rvalid;
    assign resp_data_n = (mem_rvalid && !req_q.wen) ? mem_rdata : '0;

    assign mem_req_valid = (state == REQ);
    assign mem_addr      = req_q.addr;
    assign mem_wen       = req_q.wen;
    assign mem_wdata     = req_q.wdata;
    assign mem_size      = req_q.size;
    assign mem_sext      = req_q.sext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            req_q          <= '0;
            owner          <= OWN_IFU;
            last_grant     <= OWN_LSU;
            cnt            <= '0;
            ifu_resp_valid <= 1'b0;
            ifu_resp_data  <= '0;
            ifu_resp_err   <= 1'b0;
            lsu_resp_valid <= 1'b0;
            lsu_resp_data  <= '0;
            lsu_resp_err   <= 1'b0;
        end else begin
            ifu_resp_valid <= 1'b0;
            lsu_resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_q      <= win_req;
                        owner      <= grant_lsu;
                        last_grant <= grant_lsu;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        cnt   <= '0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (resp_fire) begin
                        state <= IDLE;
                        if (owner == OWN_LSU) begin
                            lsu_resp_valid <= 1'b1;
                            lsu_resp_data  <= resp_data_n;
                            lsu_resp_err   <= resp_err_n;
                        end else begin
                            ifu_resp_valid <= 1'b1;
                            ifu_resp_data  <= resp_data_n;
                            ifu_resp_err   <= resp_err_n;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
